// File: rtl/u712_sdram_init_refresh.sv
// u712_sdram_init_refresh
// Power-up init sequencer and auto-refresh scheduler for the U712 chip-RAM SDRAM.
// Owns the command pins through the JEDEC init sequence, then requests the bus
// via REF_REQ/REF_ACK to issue AUTO REFRESH from a saturating backlog.
// Everything is clocked on the falling edge of CLK80, like the chip-RAM state machine.
// TRP, TRC and TMRD are assumed to be at least 2 (each has a wait state of length-1).
`timescale 1ns/1ps
module u712_sdram_init_refresh #(
    parameter int          POWERUP_CYCLES   = 8000,
    parameter int          TRP              = 2,
    parameter int          TRC              = 6,
    parameter int          TMRD             = 2,
    parameter int          REFRESH_INTERVAL = 624,
    parameter int          MAX_PENDING      = 8,
    parameter logic [10:0] MODE_REG         = 11'h020
) (
    input  logic        CLK80,
    input  logic        RESETn,
    input  logic        REF_ACK,
    output logic        INIT_DONE,
    output logic        REF_REQ,
    output logic        REF_URGENT,
    output logic        REF_DONE,
    output logic        CMD_OWN,
    output logic        SD_RASn,
    output logic        SD_CASn,
    output logic        SD_WEn,
    output logic [1:0]  SD_BA,
    output logic [10:0] SD_A
);

    localparam int CNT_W  = $clog2(POWERUP_CYCLES + TRP + TRC + TMRD + 1);
    localparam int ICNT_W = $clog2(REFRESH_INTERVAL + 1);

    // Wait states exit when the counter (zeroed on entry) reaches length-2.
    localparam logic [CNT_W-1:0]  C_PWRUP    = CNT_W'(POWERUP_CYCLES);
    localparam logic [CNT_W-1:0]  C_TRP      = CNT_W'(TRP - 2);
    localparam logic [CNT_W-1:0]  C_TRC      = CNT_W'(TRC - 2);
    localparam logic [CNT_W-1:0]  C_TMRD     = CNT_W'(TMRD - 2);
    localparam logic [ICNT_W-1:0] C_INT_LAST = ICNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [3:0]        C_MAXP     = 4'(MAX_PENDING);

    typedef enum logic [3:0] {
        S_PWRUP_WAIT,
        S_PRE,
        S_PRE_WAIT,
        S_REF1,
        S_REF1_WAIT,
        S_REF2,
        S_REF2_WAIT,
        S_MRS,
        S_MRS_WAIT,
        S_IDLE,
        S_AREF,
        S_AREF_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ICNT_W-1:0]   r_icnt;
    logic [3:0]          r_pending;
    logic [3:0]          w_pend_nxt;
    logic                w_tick;
    logic                w_dec;

    logic                r_init_done;
    logic                r_ref_req;
    logic                r_ref_done;
    logic                r_cmd_own;
    logic                r_rasn;
    logic                r_casn;
    logic                r_wen;
    logic [10:0]         r_sd_a;

    logic                w_init_done;
    logic                w_ref_req;
    logic                w_ref_done;
    logic                w_cmd_own;
    logic                w_rasn;
    logic                w_casn;
    logic                w_wen;
    logic [10:0]         w_sd_a;

    // One tick per wrap of the interval counter, only once init has finished.
    assign w_tick = r_init_done && (r_icnt == C_INT_LAST);

    // Next-state logic: init timeline, then IDLE/AREF/AREF_WAIT refresh service.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_dec       = 1'b0;
        case (r_state)
            S_PWRUP_WAIT: begin
                if (r_cnt == C_PWRUP) w_state_nxt = S_PRE;
                else                  w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_PRE:        w_state_nxt = S_PRE_WAIT;
            S_PRE_WAIT: begin
                if (r_cnt == C_TRP) w_state_nxt = S_REF1;
                else                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_REF1:       w_state_nxt = S_REF1_WAIT;
            S_REF1_WAIT: begin
                if (r_cnt == C_TRC) w_state_nxt = S_REF2;
                else                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_REF2:       w_state_nxt = S_REF2_WAIT;
            S_REF2_WAIT: begin
                if (r_cnt == C_TRC) w_state_nxt = S_MRS;
                else                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_MRS:        w_state_nxt = S_MRS_WAIT;
            S_MRS_WAIT: begin
                if (r_cnt == C_TMRD) w_state_nxt = S_IDLE;
                else                 w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_IDLE: begin
                // The grant only counts when there is work to do.
                if (REF_ACK && (r_pending != 4'd0)) begin
                    w_state_nxt = S_AREF;
                    w_dec       = 1'b1;
                end
            end
            S_AREF:       w_state_nxt = S_AREF_WAIT;
            S_AREF_WAIT: begin
                if (r_cnt == C_TRC) w_state_nxt = S_IDLE;
                else                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            default:      w_state_nxt = S_PWRUP_WAIT;
        endcase
    end

    // Backlog update: a tick and a refresh on the same edge cancel out.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_tick && !w_dec) begin
            if (r_pending < C_MAXP) w_pend_nxt = r_pending + 4'd1;
        end else if (w_dec && !w_tick) begin
            w_pend_nxt = r_pending - 4'd1;
        end
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        w_rasn      = 1'b1;
        w_casn      = 1'b1;
        w_wen       = 1'b1;
        w_sd_a      = 11'h000;
        w_cmd_own   = (w_state_nxt != S_IDLE);
        w_init_done = r_init_done || (w_state_nxt == S_IDLE);
        w_ref_req   = (w_state_nxt == S_IDLE) && (w_pend_nxt != 4'd0);
        w_ref_done  = (w_state_nxt == S_AREF_WAIT) && (w_cnt_nxt == C_TRC);
        case (w_state_nxt)
            S_PRE: begin
                w_rasn = 1'b0;
                w_wen  = 1'b0;
                w_sd_a = 11'h400;
            end
            S_REF1, S_REF2, S_AREF: begin
                w_rasn = 1'b0;
                w_casn = 1'b0;
            end
            S_MRS: begin
                w_rasn = 1'b0;
                w_casn = 1'b0;
                w_wen  = 1'b0;
                w_sd_a = MODE_REG;
            end
            default: ;
        endcase
    end

    // State, sequencing counter, backlog and registered outputs.
    always_ff @(negedge CLK80) begin
        if (!RESETn) begin
            r_state     <= S_PWRUP_WAIT;
            r_cnt       <= '0;
            r_pending   <= 4'd0;
            r_init_done <= 1'b0;
            r_ref_req   <= 1'b0;
            r_ref_done  <= 1'b0;
            r_cmd_own   <= 1'b1;
            r_rasn      <= 1'b1;
            r_casn      <= 1'b1;
            r_wen       <= 1'b1;
            r_sd_a      <= 11'h000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pending   <= w_pend_nxt;
            r_init_done <= w_init_done;
            r_ref_req   <= w_ref_req;
            r_ref_done  <= w_ref_done;
            r_cmd_own   <= w_cmd_own;
            r_rasn      <= w_rasn;
            r_casn      <= w_casn;
            r_wen       <= w_wen;
            r_sd_a      <= w_sd_a;
        end
    end

    // Refresh interval counter, free-running once init is done.
    always_ff @(negedge CLK80) begin
        if (!RESETn)          r_icnt <= '0;
        else if (w_tick)      r_icnt <= '0;
        else if (r_init_done) r_icnt <= r_icnt + ICNT_W'(1);
    end

    assign INIT_DONE  = r_init_done;
    assign REF_REQ    = r_ref_req;
    assign REF_URGENT = (r_pending == C_MAXP);
    assign REF_DONE   = r_ref_done;
    assign CMD_OWN    = r_cmd_own;
    assign SD_RASn    = r_rasn;
    assign SD_CASn    = r_casn;
    assign SD_WEn     = r_wen;
    assign SD_BA      = 2'b00;
    assign SD_A       = r_sd_a;

endmodule

// File: tb/tb_u712_sdram_init_refresh.sv
// Testbench for u712_sdram_init_refresh: behavioural reference model feeding a
// scoreboard queue, a monitor comparing every registered output each cycle,
// plus directed checks on init timing, backlog saturation and draining.
`timescale 1ns/1ps
module tb_u712_sdram_init_refresh;

    localparam int          P      = 8000;
    localparam int          TRP    = 2;
    localparam int          TRC    = 6;
    localparam int          TMRD   = 2;
    localparam int          INTV   = 624;
    localparam int          MAXP   = 8;
    localparam logic [10:0] MODE   = 11'h020;
    localparam int          T_INIT = P + TRP + 2 * TRC + TMRD;

    typedef struct packed {
        logic        init_done;
        logic        req;
        logic        urgent;
        logic        done;
        logic        own;
        logic        ras;
        logic        cas;
        logic        we;
        logic [1:0]  ba;
        logic [10:0] a;
    } obs_t;

    logic        CLK80 = 1'b0;
    logic        RESETn;
    logic        REF_ACK;
    logic        INIT_DONE, REF_REQ, REF_URGENT, REF_DONE, CMD_OWN;
    logic        SD_RASn, SD_CASn, SD_WEn;
    logic [1:0]  SD_BA;
    logic [10:0] SD_A;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    // Reference model state (spec-level quantities, not the DUT's encoding)
    int m_c;      // cycle index since reset release, used during init
    bit m_init;   // init sequence finished
    int m_pend;   // refresh backlog
    int m_icnt;   // cycles since last tick
    int m_left;   // remaining bus-owned cycles of the current refresh
    bit m_idle;   // bus released, refresh service may start

    u712_sdram_init_refresh dut (
        .CLK80      (CLK80),
        .RESETn     (RESETn),
        .REF_ACK    (REF_ACK),
        .INIT_DONE  (INIT_DONE),
        .REF_REQ    (REF_REQ),
        .REF_URGENT (REF_URGENT),
        .REF_DONE   (REF_DONE),
        .CMD_OWN    (CMD_OWN),
        .SD_RASn    (SD_RASn),
        .SD_CASn    (SD_CASn),
        .SD_WEn     (SD_WEn),
        .SD_BA      (SD_BA),
        .SD_A       (SD_A)
    );

    always #5 CLK80 = ~CLK80;

    // Reference model: evaluates the same falling edge and queues the expected outputs.
    always @(negedge CLK80) begin : model
        obs_t e;
        bit   tick;
        bit   dec;
        e     = '0;
        e.ras = 1'b1;
        e.cas = 1'b1;
        e.we  = 1'b1;
        e.own = 1'b1;
        if (!RESETn) begin
            m_c = 0; m_init = 0; m_pend = 0; m_icnt = 0; m_left = 0; m_idle = 0;
        end else if (!m_init) begin
            if (m_c == P) begin
                e.ras = 1'b0; e.we = 1'b0; e.a = 11'h400;
            end else if (m_c == P + TRP || m_c == P + TRP + TRC) begin
                e.ras = 1'b0; e.cas = 1'b0;
            end else if (m_c == P + TRP + 2 * TRC) begin
                e.ras = 1'b0; e.cas = 1'b0; e.we = 1'b0; e.a = MODE;
            end else if (m_c == T_INIT) begin
                m_init = 1; m_idle = 1; m_icnt = 0; e.own = 1'b0;
            end
            m_c++;
        end else begin
            m_icnt++;
            tick = (m_icnt == INTV);
            if (tick) m_icnt = 0;
            dec = 0;
            if (m_idle && REF_ACK && m_pend > 0) begin
                dec = 1; e.ras = 1'b0; e.cas = 1'b0; m_left = TRC - 1; m_idle = 0;
            end else if (m_left > 0) begin
                e.done = (m_left == 1);
                m_left--;
            end else begin
                e.own = 1'b0; m_idle = 1;
            end
            if (tick && !dec) begin
                if (m_pend < MAXP) m_pend++;
            end else if (dec && !tick) begin
                m_pend--;
            end
        end
        e.init_done = m_init;
        e.req       = m_idle && (m_pend > 0);
        e.urgent    = (m_pend == MAXP);
        exp_q.push_back(e);
    end

    // Monitor: mid-cycle, pop the expected record and compare all outputs.
    always @(posedge CLK80) begin : monitor
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {INIT_DONE, REF_REQ, REF_URGENT, REF_DONE, CMD_OWN,
                 SD_RASn, SD_CASn, SD_WEn, SD_BA, SD_A};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs @%0t: got init=%b req=%b urg=%b done=%b own=%b cmd=%b%b%b ba=%h a=%h, expected init=%b req=%b urg=%b done=%b own=%b cmd=%b%b%b ba=%h a=%h",
                         $time, a.init_done, a.req, a.urgent, a.done, a.own, a.ras, a.cas, a.we, a.ba, a.a,
                         e.init_done, e.req, e.urgent, e.done, e.own, e.ras, e.cas, e.we, e.ba, e.a);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    // Counts cycles from reset release until INIT_DONE rises.
    task automatic wait_init(input string nm);
        int k;
        k = -1;
        for (int i = 0; i < T_INIT + 200; i++) begin
            @(negedge CLK80);
            #1;
            if (INIT_DONE === 1'b1) begin
                k = i;
                break;
            end
        end
        chk(nm, k, T_INIT);
    endtask

    task automatic count_aref(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge CLK80);
            if (SD_RASn === 1'b0 && SD_CASn === 1'b0 && SD_WEn === 1'b1) n++;
        end
    endtask

    initial begin : stim
        int n;
        bit found;
        RESETn  = 1'b0;
        REF_ACK = 1'b0;
        repeat (3) @(posedge CLK80);
        chk("reset_own", CMD_OWN, 1);
        chk("reset_init_done", INIT_DONE, 0);

        // Grant held high through power-up must not disturb the init timeline.
        RESETn  = 1'b1;
        REF_ACK = 1'b1;
        wait_init("init_done_cycle");

        // Grant tied high: each tick is serviced right away.
        @(posedge CLK80);
        repeat (3 * INTV) @(posedge CLK80);

        // Starve the scheduler: backlog saturates.
        REF_ACK = 1'b0;
        repeat (9 * INTV + 10) @(posedge CLK80);
        chk("urgent_saturated", REF_URGENT, 1);
        chk("req_saturated", REF_REQ, 1);

        // Drain well away from the next tick.
        found = 0;
        for (int i = 0; i < 2 * INTV; i++) begin
            @(posedge CLK80);
            if (m_icnt == 100) begin found = 1; break; end
        end
        chk("drain_align", found, 1);
        REF_ACK = 1'b1;
        count_aref(60, n);
        chk("drain_aref_count", n, MAXP);
        chk("drain_req_low", REF_REQ, 0);
        chk("drain_urgent_low", REF_URGENT, 0);

        // Tick landing on the same edge as an AREF at backlog 3.
        REF_ACK = 1'b0;
        found = 0;
        for (int i = 0; i < 5 * INTV; i++) begin
            @(posedge CLK80);
            if (m_pend == 3 && m_icnt == INTV - 1) begin found = 1; break; end
        end
        chk("coincide_align", found, 1);
        REF_ACK = 1'b1;
        @(posedge CLK80);
        REF_ACK = 1'b0;
        chk("coincide_aref", {SD_RASn, SD_CASn, SD_WEn}, 3'b001);
        repeat (10) @(posedge CLK80);
        REF_ACK = 1'b1;
        count_aref(30, n);
        chk("coincide_backlog", n, 3);

        // Random grant pattern.
        repeat (3000) begin
            @(posedge CLK80);
            REF_ACK = ($urandom_range(0, 9) < 3);
        end

        // Reset pulse in the middle of a refresh window.
        REF_ACK = 1'b1;
        found = 0;
        for (int i = 0; i < 2 * INTV; i++) begin
            @(posedge CLK80);
            if (INIT_DONE === 1'b1 && CMD_OWN === 1'b1 && SD_RASn === 1'b1) begin
                found = 1; break;
            end
        end
        chk("aref_wait_found", found, 1);
        repeat ($urandom_range(0, 3)) @(posedge CLK80);
        RESETn = 1'b0;
        @(posedge CLK80);
        chk("rst_mid_own", CMD_OWN, 1);
        chk("rst_mid_init_done", INIT_DONE, 0);
        chk("rst_mid_cmd", {SD_RASn, SD_CASn, SD_WEn}, 3'b111);
        chk("rst_mid_req", REF_REQ, 0);
        RESETn = 1'b1;
        wait_init("reinit_done_cycle");

        // Random grant after re-init, long enough to see refreshes again.
        repeat (2 * INTV + 100) begin
            @(posedge CLK80);
            REF_ACK = ($urandom_range(0, 1) == 1);
        end
        @(posedge CLK80);
        @(posedge CLK80);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
